w_stage_grf: RTL and testbench
==============================

# w_stage_grf

Writeback stage and general register file for the five-stage MIPS pipeline. It consumes the W-stage pipeline register outputs, selects the writeback value, and commits it to a 32×32 register file. It serves decode-stage reads with same-cycle write-through bypass. It also exposes a commit trace and a retired-instruction counter for the verification bench.

## Interface
- COUNT_W, 32, width of the retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clock clk
- RegWrite_W  in  1  write enable from the W pipeline register
- MemtoReg_W  in  1  1 selects ReadData_W, 0 selects ALUOut_W (used only when WriteSel_W=00)
- WriteSel_W  in  2  00 ALU/Mem, 01 PC_W+8 (link), 10 {SignImm_W[15:0],16'h0} (lui), 11 reserved → 32'h0
- ReadData_W  in  32  load data
- ALUOut_W  in  32  ALU result
- WriteReg_W  in  5  destination register index
- SignImm_W  in  32  sign-extended immediate
- PC_W  in  32  PC of the instruction in W
- Instr_W  in  32  instruction word in W; 32'h0 means bubble
- A1, A2  in  5 each  decode-stage read addresses
- RD1, RD2  out  32 each  read data, combinational
- WD_W  out  32  selected writeback value, combinational
- wb_valid  out  1  registered: a commit happened on the previous edge
- wb_pc  out  32  registered PC of that commit
- wb_reg  out  5  registered destination of that commit
- wb_data  out  32  registered data of that commit
- retire_count  out  COUNT_W  registered count of non-bubble instructions retired

## Operation
- WD_W is derived from WriteSel_W as listed. The PC_W+8 addition is modulo 2^32.
- Commit condition is `we = RegWrite_W & (WriteReg_W != 0) & ~reset`. On the edge where `we` is true, `grf[WriteReg_W] <= WD_W`.
- grf[0] reads 0 at all times. A write to $0 is dropped, produces no trace, and is not counted as a commit.
- Read RDn:
  - If reset is high, RDn = 0.
  - Else if An == 0, RDn = 0.
  - Else if `we` and An == WriteReg_W, RDn = WD_W (write-through bypass).
  - Else RDn = grf[An].
  - A1 and A2 are independent. Both may hit the bypass in the same cycle.
- Trace: on each edge, `wb_valid <= we`. When `we` is true, wb_pc, wb_reg and wb_data load PC_W, WriteReg_W and WD_W. Otherwise they hold their previous values.
- retire_count increments by 1 on each edge where reset is low and Instr_W != 0, regardless of RegWrite_W. It wraps from 2^COUNT_W−1 to 0.

## Timing
- Reset takes effect on the edge where reset is high. After that edge, grf[1..31], wb_valid, wb_pc, wb_reg, wb_data and retire_count are all 0.
- While reset is high:
  - RD1 = RD2 = 0.
  - Writes are suppressed, including a W instruction that is in flight when reset rises mid-run. That instruction is lost.
- Write latency: register content is visible through grf one edge after commit. The bypass makes it visible to RDn in the commit cycle itself, so decode needs no extra forwarding from W.
- Trace and counter latency: one edge. wb_* describe the commit of the previous cycle.
- No stall input. The stage commits every cycle, and bubbles arrive as all-zero W registers.

## Test plan
- Reset and empty: hold reset for 2 cycles, then read A1=5, A2=31 → RD1=RD2=0, retire_count=0, wb_valid=0.
- Commit and readback: write ALUOut_W=32'h1234_5678 to $8 with WriteSel=00, MemtoReg=0 and Instr non-zero.
  - Next cycle, A1=8 → RD1=32'h1234_5678.
  - wb_valid=1, wb_reg=8, wb_data=32'h1234_5678.
  - retire_count=1.
- Source select:
  - MemtoReg=1, ReadData=32'hDEAD_BEEF → $9=32'hDEAD_BEEF.
  - WriteSel=01, PC_W=32'h0000_3000, WriteReg=31 → $31=32'h0000_3008.
  - WriteSel=10, SignImm=32'hFFFF_ABCD → 32'hABCD_0000.
  - WriteSel=11 → 32'h0.
- Bypass: in the same cycle as a commit of 32'hCAFE to $4, set A1=A2=4 → RD1=RD2=32'hCAFE before the edge. The grf value after the edge is identical.
- $0 and bubbles:
  - Write 32'hFFFF_FFFF to $0 → RD with A1=0 stays 0, wb_valid=0, retire_count increments.
  - Instr_W=0 with RegWrite_W=0 → no count change.
- Reset mid-operation and counter wrap:
  - Assert reset in the same cycle as a $5 commit → $5=0 afterwards and retire_count=0.
  - With COUNT_W=4, retire 17 instructions → retire_count=1.

Source files
------------

// File: rtl/w_stage_grf.sv
// ---------------------------------------------------------------------------
// w_stage_grf
//
// Writeback stage and general register file of the five-stage MIPS pipeline.
// Selects the writeback value from the W pipeline register, commits it into
// a 32 x 32 register file, and serves the two decode-stage read ports. The
// read ports include a same-cycle write-through bypass, so decode never needs
// forwarding from W. A registered commit trace and a retired-instruction
// counter are provided for observation.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   RegWrite_W          write enable of the instruction in W
//   MemtoReg_W          1: ReadData_W, 0: ALUOut_W (only when WriteSel_W=00)
//   WriteSel_W          00 ALU/Mem, 01 PC_W+8, 10 lui, 11 zero
//   ReadData_W          load data
//   ALUOut_W            ALU result
//   WriteReg_W          destination register index
//   SignImm_W           sign-extended immediate
//   PC_W                PC of the instruction in W
//   Instr_W             instruction word in W (32'h0 is a bubble)
//   A1, A2              decode read addresses
//   RD1, RD2            decode read data (combinational)
//   WD_W                selected writeback value (combinational)
//   wb_valid            a commit happened on the previous edge
//   wb_pc/wb_reg/wb_data  PC, destination and data of that commit
//   retire_count        count of non-bubble instructions retired
//
// Handshake: there is none. The stage accepts one W instruction on every
// rising edge with no stall; bubbles are all-zero W registers.
// ---------------------------------------------------------------------------
module w_stage_grf #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWrite_W,
    input  logic               MemtoReg_W,
    input  logic [1:0]         WriteSel_W,
    input  logic [31:0]        ReadData_W,
    input  logic [31:0]        ALUOut_W,
    input  logic [4:0]         WriteReg_W,
    input  logic [31:0]        SignImm_W,
    input  logic [31:0]        PC_W,
    input  logic [31:0]        Instr_W,
    input  logic [4:0]         A1,
    input  logic [4:0]         A2,
    output logic [31:0]        RD1,
    output logic [31:0]        RD2,
    output logic [31:0]        WD_W,
    output logic               wb_valid,
    output logic [31:0]        wb_pc,
    output logic [4:0]         wb_reg,
    output logic [31:0]        wb_data,
    output logic [COUNT_W-1:0] retire_count
);

    // Writeback source encodings
    localparam logic [1:0] SEL_ALU_MEM = 2'b00;
    localparam logic [1:0] SEL_LINK    = 2'b01;
    localparam logic [1:0] SEL_LUI     = 2'b10;

    // Entry 0 exists only to keep indexing simple; it is never written
    // because the commit condition excludes $0, and reads of $0 are forced
    // to zero anyway.
    logic [31:0]        r_grf [0:31];
    logic               r_wb_valid;
    logic [31:0]        r_wb_pc;
    logic [4:0]         r_wb_reg;
    logic [31:0]        r_wb_data;
    logic [COUNT_W-1:0] r_retire_count;

    logic [31:0]        w_wd;
    logic               w_we;
    logic               w_retire;
    logic [31:0]        w_rd1;
    logic [31:0]        w_rd2;

    // ------------------------------------------------------------------
    // Writeback value select
    // ------------------------------------------------------------------
    always_comb begin
        w_wd = 32'h0;
        case (WriteSel_W)
            SEL_ALU_MEM: w_wd = MemtoReg_W ? ReadData_W : ALUOut_W;
            SEL_LINK:    w_wd = PC_W + 32'd8;
            SEL_LUI:     w_wd = {SignImm_W[15:0], 16'h0000};
            default:     w_wd = 32'h0;
        endcase
    end

    // Reset in the commit cycle squashes the in-flight instruction.
    assign w_we     = RegWrite_W & (WriteReg_W != 5'd0) & ~reset;
    assign w_retire = ~reset & (Instr_W != 32'h0);

    // ------------------------------------------------------------------
    // Read ports with write-through bypass
    // ------------------------------------------------------------------
    always_comb begin
        w_rd1 = 32'h0;
        if (reset || (A1 == 5'd0)) begin
            w_rd1 = 32'h0;
        end else if (w_we && (A1 == WriteReg_W)) begin
            w_rd1 = w_wd;
        end else begin
            w_rd1 = r_grf[A1];
        end
    end

    always_comb begin
        w_rd2 = 32'h0;
        if (reset || (A2 == 5'd0)) begin
            w_rd2 = 32'h0;
        end else if (w_we && (A2 == WriteReg_W)) begin
            w_rd2 = w_wd;
        end else begin
            w_rd2 = r_grf[A2];
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_grf[i] <= 32'h0;
            end
        end else if (w_we) begin
            r_grf[WriteReg_W] <= w_wd;
        end
    end

    // ------------------------------------------------------------------
    // Commit trace: payload holds its value between commits
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_pc    <= 32'h0;
            r_wb_reg   <= 5'd0;
            r_wb_data  <= 32'h0;
        end else begin
            r_wb_valid <= w_we;
            if (w_we) begin
                r_wb_pc   <= PC_W;
                r_wb_reg  <= WriteReg_W;
                r_wb_data <= w_wd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter, wraps naturally at 2^COUNT_W
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_count <= '0;
        end else if (w_retire) begin
            r_retire_count <= r_retire_count + 1'b1;
        end
    end

    assign RD1          = w_rd1;
    assign RD2          = w_rd2;
    assign WD_W         = w_wd;
    assign wb_valid     = r_wb_valid;
    assign wb_pc        = r_wb_pc;
    assign wb_reg       = r_wb_reg;
    assign wb_data      = r_wb_data;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_w_stage_grf.sv
// ---------------------------------------------------------------------------
// tb_w_stage_grf
//
// Drives the writeback stage with directed scenarios and random traffic.
// Two instances share the stimulus: one with a 32-bit retire counter and one
// with a 4-bit counter to exercise wrap-around. Expected values come from a
// behavioural model: an array register file, a counter, and a queue of the
// data each commit should report on the trace.
// ---------------------------------------------------------------------------
module tb_w_stage_grf;

    logic        clk;
    logic        reset;
    logic        RegWrite_W;
    logic        MemtoReg_W;
    logic [1:0]  WriteSel_W;
    logic [31:0] ReadData_W;
    logic [31:0] ALUOut_W;
    logic [4:0]  WriteReg_W;
    logic [31:0] SignImm_W;
    logic [31:0] PC_W;
    logic [31:0] Instr_W;
    logic [4:0]  A1;
    logic [4:0]  A2;

    logic [31:0] RD1, RD2, WD_W, wb_pc, wb_data, retire_count;
    logic        wb_valid;
    logic [4:0]  wb_reg;

    logic [31:0] RD1_4, RD2_4, WD_W_4, wb_pc_4, wb_data_4;
    logic        wb_valid_4;
    logic [4:0]  wb_reg_4;
    logic [3:0]  retire_count_4;

    int vectors;
    int errors;

    // behavioural model
    logic [31:0] m_grf [32];
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [31:0] exp_q [$];

    w_stage_grf #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W),
        .WriteSel_W(WriteSel_W), .ReadData_W(ReadData_W), .ALUOut_W(ALUOut_W),
        .WriteReg_W(WriteReg_W), .SignImm_W(SignImm_W), .PC_W(PC_W), .Instr_W(Instr_W),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WD_W(WD_W), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_reg(wb_reg), .wb_data(wb_data), .retire_count(retire_count)
    );

    w_stage_grf #(.COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W),
        .WriteSel_W(WriteSel_W), .ReadData_W(ReadData_W), .ALUOut_W(ALUOut_W),
        .WriteReg_W(WriteReg_W), .SignImm_W(SignImm_W), .PC_W(PC_W), .Instr_W(Instr_W),
        .A1(A1), .A2(A2), .RD1(RD1_4), .RD2(RD2_4), .WD_W(WD_W_4), .wb_valid(wb_valid_4),
        .wb_pc(wb_pc_4), .wb_reg(wb_reg_4), .wb_data(wb_data_4), .retire_count(retire_count_4)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // --------------------------------------------------------------------
    // Reference model
    // --------------------------------------------------------------------
    function automatic logic [31:0] ref_wd();
        case (WriteSel_W)
            2'b00:   return MemtoReg_W ? ReadData_W : ALUOut_W;
            2'b01:   return PC_W + 32'd8;
            2'b10:   return {SignImm_W[15:0], 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_we();
        return RegWrite_W && (WriteReg_W != 5'd0) && !reset;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        if (reset || a == 5'd0) return 32'h0;
        if (ref_we() && a == WriteReg_W) return ref_wd();
        return m_grf[a];
    endfunction

    // --------------------------------------------------------------------
    // Driver tasks
    // --------------------------------------------------------------------
    task automatic set_bubble();
        RegWrite_W = 1'b0; MemtoReg_W = 1'b0; WriteSel_W = 2'b00;
        ReadData_W = 32'h0; ALUOut_W = 32'h0; WriteReg_W = 5'd0;
        SignImm_W = 32'h0; PC_W = 32'h0; Instr_W = 32'h0;
    endtask

    task automatic set_alu_write(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc);
        set_bubble();
        RegWrite_W = 1'b1; WriteReg_W = rd; ALUOut_W = val; PC_W = pc;
        Instr_W = 32'h0000_0021 | {11'h0, rd, 16'h0};
    endtask

    // Advance one clock edge and move the model across it.
    task automatic tick();
        logic        we_m;
        logic [31:0] wd_m;
        we_m = ref_we();
        wd_m = ref_wd();
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_grf[i] = 32'h0;
            m_cnt = 0; m_cnt4 = 0; m_valid = 0;
            m_pc = 0; m_reg = 0; m_data = 0;
            exp_q.delete();
        end else begin
            m_valid = we_m;
            if (we_m) begin
                m_grf[WriteReg_W] = wd_m;
                m_pc   = PC_W;
                m_reg  = WriteReg_W;
                m_data = wd_m;
                exp_q.push_back(wd_m);
            end
            if (Instr_W != 32'h0) begin
                m_cnt  = m_cnt + 1;
                m_cnt4 = m_cnt4 + 1;
            end
        end
    endtask

    // --------------------------------------------------------------------
    // Scenarios
    // --------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        set_bubble();
        A1 = 5'd5; A2 = 5'd31;
        tick();
        // an in-flight write while reset is high must not show on the read ports
        set_alu_write(5'd5, 32'h0BAD_0BAD, 32'h100);
        #1;
        vectors++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd_during: RD1=%h RD2=%h expected 0", RD1, RD2);
        end
        tick();
        reset = 1'b0;
        set_bubble();
        #1;
        vectors++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd_after: RD1=%h RD2=%h expected 0", RD1, RD2);
        end
        vectors++;
        if (retire_count !== 32'h0 || wb_valid !== 1'b0 || wb_pc !== 32'h0 ||
            wb_reg !== 5'd0 || wb_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d valid=%b pc=%h reg=%0d data=%h expected all 0",
                     retire_count, wb_valid, wb_pc, wb_reg, wb_data);
        end
    endtask

    task automatic test_commit();
        set_alu_write(5'd8, 32'h1234_5678, 32'h0000_2000);
        tick();
        void'(exp_q.pop_front());
        set_bubble();
        A1 = 5'd8; A2 = 5'd0;
        #1;
        vectors++;
        if (RD1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL commit_readback: RD1=%h expected 12345678", RD1);
        end
        vectors++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd8 || wb_data !== 32'h1234_5678 ||
            wb_pc !== 32'h0000_2000) begin
            errors++;
            $display("FAIL commit_trace: valid=%b reg=%0d data=%h pc=%h expected 1 8 12345678 00002000",
                     wb_valid, wb_reg, wb_data, wb_pc);
        end
        vectors++;
        if (retire_count !== 32'd1) begin
            errors++;
            $display("FAIL commit_count: cnt=%0d expected 1", retire_count);
        end
    endtask

    task automatic test_source_select();
        logic [1:0]  sel [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [4:0]  dst [4]  = '{5'd9, 5'd31, 5'd10, 5'd9};
        logic [31:0] want [4] = '{32'hDEAD_BEEF, 32'h0000_3008, 32'hABCD_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            set_bubble();
            RegWrite_W = 1'b1; MemtoReg_W = 1'b1; WriteSel_W = sel[i];
            ReadData_W = 32'hDEAD_BEEF; ALUOut_W = 32'h1111_1111;
            SignImm_W = 32'hFFFF_ABCD; PC_W = 32'h0000_3000;
            WriteReg_W = dst[i]; Instr_W = 32'h8C00_0000 + i;
            #1;
            vectors++;
            if (WD_W !== want[i]) begin
                errors++;
                $display("FAIL src_sel_wd[%0d]: WD_W=%h expected %h", i, WD_W, want[i]);
            end
            tick();
            void'(exp_q.pop_front());
            set_bubble();
            A1 = dst[i];
            #1;
            vectors++;
            if (RD1 !== want[i] || wb_data !== want[i]) begin
                errors++;
                $display("FAIL src_sel_reg[%0d]: RD1=%h wb_data=%h expected %h", i, RD1, wb_data, want[i]);
            end
        end
        vectors++;
        if (retire_count !== m_cnt) begin
            errors++;
            $display("FAIL src_sel_count: cnt=%0d expected %0d", retire_count, m_cnt);
        end
    endtask

    task automatic test_bypass();
        set_alu_write(5'd4, 32'h0000_CAFE, 32'h0000_4000);
        A1 = 5'd4; A2 = 5'd4;
        #1;
        vectors++;
        if (RD1 !== 32'h0000_CAFE || RD2 !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL bypass_same_cycle: RD1=%h RD2=%h expected 0000cafe", RD1, RD2);
        end
        tick();
        void'(exp_q.pop_front());
        set_bubble();
        #1;
        vectors++;
        if (RD1 !== 32'h0000_CAFE || RD2 !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL bypass_after_edge: RD1=%h RD2=%h expected 0000cafe", RD1, RD2);
        end
    endtask

    task automatic test_zero_and_bubble();
        logic [31:0] cnt_before;
        logic [31:0] data_before;
        cnt_before  = retire_count;
        data_before = m_data;
        set_alu_write(5'd0, 32'hFFFF_FFFF, 32'h0000_5000);
        A1 = 5'd0;
        tick();
        set_bubble();
        #1;
        vectors++;
        if (RD1 !== 32'h0 || wb_valid !== 1'b0 || wb_data !== data_before) begin
            errors++;
            $display("FAIL zero_write: RD1=%h valid=%b data=%h expected 0 0 %h",
                     RD1, wb_valid, wb_data, data_before);
        end
        vectors++;
        if (retire_count !== cnt_before + 32'd1) begin
            errors++;
            $display("FAIL zero_write_count: cnt=%0d expected %0d", retire_count, cnt_before + 32'd1);
        end
        tick();
        vectors++;
        if (retire_count !== cnt_before + 32'd1) begin
            errors++;
            $display("FAIL bubble_count: cnt=%0d expected %0d", retire_count, cnt_before + 32'd1);
        end
    endtask

    task automatic test_reset_mid();
        set_alu_write(5'd5, 32'h0000_0077, 32'h0000_6000);
        tick();
        void'(exp_q.pop_front());
        set_alu_write(5'd5, 32'h0000_0055, 32'h0000_6004);
        reset = 1'b1;
        A1 = 5'd5;
        #1;
        vectors++;
        if (RD1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_rd: RD1=%h expected 0", RD1);
        end
        tick();
        reset = 1'b0;
        set_bubble();
        #1;
        vectors++;
        if (RD1 !== 32'h0 || retire_count !== 32'h0 || wb_valid !== 1'b0 || wb_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_state: RD1=%h cnt=%0d valid=%b data=%h expected 0",
                     RD1, retire_count, wb_valid, wb_data);
        end
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 17; i++) begin
            set_bubble();
            Instr_W = 32'h1000_0000 | i;
            tick();
        end
        set_bubble();
        #1;
        vectors++;
        if (retire_count_4 !== 4'd1) begin
            errors++;
            $display("FAIL counter_wrap4: cnt=%0d expected 1", retire_count_4);
        end
        vectors++;
        if (retire_count !== 32'd17) begin
            errors++;
            $display("FAIL counter_17: cnt=%0d expected 17", retire_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            RegWrite_W = ($urandom_range(0, 3) != 0);
            MemtoReg_W = $urandom_range(0, 1);
            WriteSel_W = $urandom_range(0, 3);
            ReadData_W = $urandom;
            ALUOut_W   = $urandom;
            WriteReg_W = $urandom_range(0, 31);
            SignImm_W  = $urandom;
            PC_W       = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            Instr_W    = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom | 32'h1);
            A1         = ($urandom_range(0, 3) == 0) ? WriteReg_W : 5'($urandom_range(0, 31));
            A2         = ($urandom_range(0, 3) == 0) ? WriteReg_W : 5'($urandom_range(0, 31));
            #1;
            vectors++;
            if (WD_W !== ref_wd() || RD1 !== ref_rd(A1) || RD2 !== ref_rd(A2)) begin
                errors++;
                $display("FAIL rand_comb[%0d]: WD=%h RD1=%h RD2=%h expected %h %h %h",
                         n, WD_W, RD1, RD2, ref_wd(), ref_rd(A1), ref_rd(A2));
            end
            tick();
            vectors++;
            if (wb_valid !== m_valid || wb_pc !== m_pc || wb_reg !== m_reg ||
                retire_count !== m_cnt || retire_count_4 !== m_cnt4) begin
                errors++;
                $display("FAIL rand_trace[%0d]: valid=%b pc=%h reg=%0d cnt=%0d cnt4=%0d expected %b %h %0d %0d %0d",
                         n, wb_valid, wb_pc, wb_reg, retire_count, retire_count_4,
                         m_valid, m_pc, m_reg, m_cnt, m_cnt4);
            end
            exp_d = m_data;
            if (m_valid && exp_q.size() > 0) exp_d = exp_q.pop_front();
            vectors++;
            if (wb_data !== exp_d) begin
                errors++;
                $display("FAIL rand_wb_data[%0d]: wb_data=%h expected %h", n, wb_data, exp_d);
            end
        end
        reset = 1'b0;
    endtask

    // --------------------------------------------------------------------
    // Sequence and report
    // --------------------------------------------------------------------
    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        A1 = 5'd0; A2 = 5'd0;
        set_bubble();
        for (int i = 0; i < 32; i++) m_grf[i] = 32'h0;
        m_cnt = 0; m_cnt4 = 0; m_valid = 0; m_pc = 0; m_reg = 0; m_data = 0;

        test_reset();
        test_commit();
        test_source_select();
        test_bypass();
        test_zero_and_bubble();
        test_reset_mid();
        test_counter_wrap();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
